// File: rtl/fft_pair_loader_if.sv
// Handshake bundle between the frame loader, its upstream sample source and the
// downstream butterfly stage.
interface fft_pair_loader_if #(
    parameter int WORD_SZ = 8
);
    logic               i_valid;
    logic [WORD_SZ-1:0] i_data;
    logic               o_ready;
    logic               o_valid;
    logic               i_ready;
    logic [WORD_SZ-1:0] out1;
    logic [WORD_SZ-1:0] out2;
    logic               o_last;

    modport master (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, out1, out2, o_last
    );

    modport slave (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, out1, out2, o_last
    );
endinterface

// File: rtl/fft_pair_loader.sv
// Buffers one frame of packed complex samples, then replays it as butterfly operand
// pairs (k, k+N/2) with valid/ready flow control toward butterfly_sum.
module fft_pair_loader #(
    parameter int WORD_SZ = 8,
    parameter int N_PTS   = 8
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    fft_pair_loader_if.master   bus
);
    localparam int IDX_W = $clog2(N_PTS);
    localparam int PR_W  = IDX_W - 1;
    localparam logic [IDX_W-1:0] HALF_IDX  = IDX_W'(N_PTS / 2);
    localparam logic [IDX_W-1:0] LAST_SAMP = IDX_W'(N_PTS - 1);
    localparam logic [PR_W-1:0]  LAST_PAIR = PR_W'(N_PTS / 2 - 1);

    typedef enum logic {
        LOAD,
        ISSUE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   wrIdx_q;
    logic [PR_W-1:0]    prIdx_q;
    logic [PR_W-1:0]    prIdx_d;
    logic [WORD_SZ-1:0] mem_q [N_PTS];
    logic [WORD_SZ-1:0] out1_q;
    logic [WORD_SZ-1:0] out2_q;
    logic               valid_q;
    logic               last_q;

    logic               sampleAccept;
    logic               pairTake;
    logic               lastSample;
    logic               lastPair;
    logic [IDX_W-1:0]   lowIdx;
    logic [IDX_W-1:0]   highIdx;

    // The two operand addresses of the next pair differ only in their top bit.
    always_comb begin
        prIdx_d      = prIdx_q + 1'b1;
        lowIdx       = {1'b0, prIdx_d};
        highIdx      = {1'b1, prIdx_d};
        sampleAccept = (state_q == LOAD) && bus.i_valid;
        pairTake     = valid_q && bus.i_ready;
        lastSample   = (wrIdx_q == LAST_SAMP);
        lastPair     = (prIdx_q == LAST_PAIR);
    end

    always_ff @(posedge i_CLK) begin
        if (sampleAccept) begin
            mem_q[wrIdx_q] <= bus.i_data;
        end
    end

    // Pair 0 is read from the array on the same edge that stores the final sample;
    // this is safe because element N-1 never belongs to pair 0.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q <= LOAD;
            wrIdx_q <= '0;
            prIdx_q <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (sampleAccept) begin
                        wrIdx_q <= wrIdx_q + 1'b1;
                        if (lastSample) begin
                            prIdx_q <= '0;
                            out1_q  <= mem_q[0];
                            out2_q  <= mem_q[HALF_IDX];
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (pairTake) begin
                        if (lastPair) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= LOAD;
                        end else begin
                            prIdx_q <= prIdx_d;
                            out1_q  <= mem_q[lowIdx];
                            out2_q  <= mem_q[highIdx];
                            last_q  <= (prIdx_d == LAST_PAIR);
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus.o_ready = (state_q == LOAD);
    assign bus.o_valid = valid_q;
    assign bus.out1    = out1_q;
    assign bus.out2    = out2_q;
    assign bus.o_last  = last_q;
endmodule

// File: tb/tb_fft_pair_loader.sv
// Scoreboard bench for fft_pair_loader: a frame-level model queues expected pairs as
// samples are accepted, and a negedge monitor checks every presented pair against it.
module tb_fft_pair_loader;
    localparam int N    = 8;
    localparam int HALF = N / 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
    } pair_t;

    logic clock;
    logic resetN;

    fft_pair_loader_if #(.WORD_SZ(8)) bus ();

    fft_pair_loader #(.WORD_SZ(8), .N_PTS(N)) dut (
        .i_CLK  (clock),
        .i_RESET(resetN),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int readyMode   = 0;
    int holdCnt     = 0;

    pair_t      expQ[$];
    logic [7:0] frameBuf[$];
    int         startStamps[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Downstream ready: always 1, random, or a 3-cycle stall while pair (0x22,0x66) shows.
    always @(posedge clock) begin
        #1;
        case (readyMode)
            0: bus.i_ready = 1'b1;
            1: bus.i_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (bus.o_valid && bus.out1 == 8'h22 && holdCnt < 3) begin
                    bus.i_ready = 1'b0;
                    holdCnt++;
                end else begin
                    bus.i_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor and reference model: the block is loading exactly when no pairs are pending.
    always @(negedge clock) begin
        cycle++;
        if (!resetN) begin
            checkOutput("rst_o_valid", 32'(bus.o_valid), 32'd0);
            checkOutput("rst_o_ready", 32'(bus.o_ready), 32'd1);
            checkOutput("rst_o_last", 32'(bus.o_last), 32'd0);
            checkOutput("rst_out1", 32'(bus.out1), 32'd0);
            checkOutput("rst_out2", 32'(bus.out2), 32'd0);
            expQ.delete();
            frameBuf.delete();
        end else begin
            checkOutput("o_ready", 32'(bus.o_ready), 32'(expQ.size() == 0));
            checkOutput("o_valid", 32'(bus.o_valid), 32'(expQ.size() != 0));
            if (bus.o_valid && expQ.size() != 0) begin
                checkOutput("out1", 32'(bus.out1), 32'(expQ[0].a));
                checkOutput("out2", 32'(bus.out2), 32'(expQ[0].b));
                checkOutput("o_last", 32'(bus.o_last), 32'(expQ[0].last));
                if (bus.i_ready) void'(expQ.pop_front());
            end
            if (bus.i_valid && bus.o_ready) begin
                if (frameBuf.size() == 0) startStamps.push_back(cycle);
                frameBuf.push_back(bus.i_data);
                if (frameBuf.size() == N) begin
                    for (int k = 0; k < HALF; k++) begin
                        expQ.push_back('{a: frameBuf[k], b: frameBuf[k + HALF], last: (k == HALF - 1)});
                    end
                    frameBuf.delete();
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] s, input int gaps, input bit junk);
        int guard;
        guard = 0;
        repeat (gaps) begin
            bus.i_valid = 1'b0;
            @(posedge clock); #1;
        end
        while (!bus.o_ready) begin
            bus.i_valid = junk;
            bus.i_data  = junk ? 8'hFF : 8'h00;
            @(posedge clock); #1;
            guard++;
            if (guard > 200) begin
                checkOutput("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.i_valid = 1'b1;
        bus.i_data  = s;
        @(posedge clock); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] base, input logic [7:0] step, input int gaps, input bit junk);
        for (int i = 0; i < N; i++) begin
            applyStimulus(8'(base + step * 8'(i)), gaps, junk);
        end
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || !bus.o_ready) && guard < 500) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("drain_timeout", 32'(guard >= 500), 32'd0);
    endtask

    initial begin
        int guard;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_ready = 1'b1;
        resetN      = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;

        readyMode = 0;
        sendFrame(8'h11, 8'h11, 0, 1'b0);
        waitDrain();

        readyMode = 2;
        holdCnt   = 0;
        sendFrame(8'h11, 8'h11, 0, 1'b0);
        waitDrain();
        checkOutput("stall_cycles", 32'(holdCnt), 32'd3);

        readyMode = 0;
        sendFrame(8'h11, 8'h11, 2, 1'b0);
        waitDrain();

        sendFrame(8'h11, 8'h11, 0, 1'b0);
        sendFrame(8'h31, 8'h02, 0, 1'b1);
        waitDrain();

        sendFrame(8'h11, 8'h11, 0, 1'b0);
        guard = 0;
        while (!(bus.o_valid && bus.out1 == 8'h22) && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("pair1_timeout", 32'(guard >= 100), 32'd0);
        resetN = 1'b0;
        #1;
        checkOutput("async_o_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("async_o_ready", 32'(bus.o_ready), 32'd1);
        checkOutput("async_out1", 32'(bus.out1), 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b1;

        startStamps.delete();
        sendFrame(8'hA1, 8'h01, 0, 1'b0);
        sendFrame(8'h5C, 8'h07, 0, 1'b0);
        waitDrain();
        checkOutput("b2b_frames", 32'(startStamps.size()), 32'd2);
        if (startStamps.size() >= 2) begin
            checkOutput("b2b_period", 32'(startStamps[1] - startStamps[0]), 32'd12);
        end

        readyMode = 1;
        for (int f = 0; f < 15; f++) begin
            bit jk;
            jk = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                applyStimulus(8'($urandom), int'($urandom_range(0, 2)), jk);
            end
        end
        waitDrain();
        repeat (3) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_pair_loader.md
# fft_pair_loader

Input frame buffer and pair sequencer placed directly upstream of `butterfly_sum`. It accepts a frame of `N_PTS` packed complex samples one per handshake and stores them in an internal register array. It then presents the samples as butterfly operand pairs, element k on `out1` and element k+`N_PTS`/2 on `out2`, with valid/ready flow control. Its outputs connect directly to the `in1`/`in2` ports of `butterfly_sum`.

## Interface
- `WORD_SZ`, 8: packed sample width; real part in the upper half, imaginary part in the lower half (passed through untouched).
- `N_PTS`, 8: frame length; power of two, ≥ 4.
- `i_CLK` input 1: clock, rising edge.
- `i_RESET` input 1: asynchronous, active-low reset (asserted at 0).
- `i_valid` input 1: upstream sample valid.
- `i_data` input `WORD_SZ`: upstream sample.
- `o_ready` output 1: block can accept a sample this cycle.
- `o_valid` output 1: `out1`/`out2` hold a valid pair.
- `i_ready` input 1: downstream accepts the pair this cycle.
- `out1` output `WORD_SZ`: first butterfly operand, element p.
- `out2` output `WORD_SZ`: second butterfly operand, element p+`N_PTS`/2.
- `o_last` output 1: the current pair is the final pair of the frame.

## Operation
- Storage: `N_PTS` × `WORD_SZ` register array.
  - Write counter `wr_idx`, $clog2(`N_PTS`) bits.
  - Pair counter `pr_idx`, $clog2(`N_PTS`)-1 bits.
- FSM states are LOAD and ISSUE. Reset state is LOAD.
- LOAD:
  - `o_ready`=1 and `o_valid`=0.
  - A sample is accepted when `i_valid`&&`o_ready`. The accepted sample is written to `mem[wr_idx]` and `wr_idx` increments.
  - Cycles with `i_valid`=0 are idle gaps. No write occurs and no counter changes.
  - When sample `N_PTS`-1 is accepted:
    - `wr_idx` wraps to 0.
    - `pr_idx` is set to 0.
    - `out1`←`mem[0]` and `out2`←`mem[N_PTS/2]`.
    - `o_valid`←1.
    - The state moves to ISSUE.
  - Valid for `N_PTS`≥4, because sample `N_PTS`-1 is not an operand of pair 0.
- ISSUE:
  - `o_ready`=0. `i_valid` is ignored and nothing is written.
  - A pair is consumed when `o_valid`&&`i_ready`.
  - On consuming a non-last pair: `pr_idx` increments and the next pair is loaded into `out1`/`out2` on the same edge. No bubble.
  - On consuming the last pair (`pr_idx`=`N_PTS`/2-1):
    - `o_valid`←0.
    - The state moves to LOAD.
    - `out1`/`out2` hold their last values.
  - While `i_ready`=0, `out1`, `out2`, `o_valid` and `o_last` stay stable.
- `o_last` = (state==ISSUE) && (`pr_idx`==`N_PTS`/2-1).
- `o_ready` = (state==LOAD). It is a combinational decode of the state register.
- Data is not modified. No arithmetic is applied to samples; halves are not split.

## Timing
- Reset values, asynchronous on `i_RESET`=0:
  - State is LOAD.
  - `wr_idx`=0 and `pr_idx`=0.
  - `out1`=0 and `out2`=0.
  - `o_valid`=0 and `o_last`=0.
  - `o_ready`=1.
  - The memory array is not reset.
- Latency: the last sample is accepted at edge t, and pair 0 is valid on `out1`/`out2` in the cycle after edge t.
- Throughput:
  - 1 pair per cycle when `i_ready`=1.
  - 1 sample per cycle in LOAD.
  - One frame costs `N_PTS` + `N_PTS`/2 cycles minimum.
- Turnaround: the last pair is consumed at edge t, and `o_ready`=1 in the cycle after edge t. There are no dead cycles between frames.
- Reset mid-frame in either state:
  - The partial frame is discarded.
  - `o_valid` drops immediately.
  - The next accepted sample is stored as element 0.
- `i_valid` during ISSUE has no effect. Upstream must hold the sample until `o_ready`=1.

## Test plan
- Single frame, `N_PTS`=8, `i_ready`=1:
  - Stimulus: samples 0x11,0x22,…,0x88 on consecutive cycles.
  - Required: pairs (0x11,0x55), (0x22,0x66), (0x33,0x77), (0x44,0x88) on 4 consecutive cycles starting the cycle after 0x88 is accepted.
  - Required: `o_last` high only with the (0x44,0x88) pair.
  - Required: `o_ready` high again the cycle after that pair.
- Backpressure:
  - Stimulus: `i_ready` held 0 for 3 cycles while (0x22,0x66) is presented.
  - Required: outputs and `o_valid` stable throughout.
  - Required: (0x33,0x77) appears the cycle after `i_ready` returns to 1.
- Input gaps: `i_valid` toggling 1,0,0,1,… over the frame -> same pair sequence as the single-frame test, with no duplicated or skipped samples.
- Ignored input in ISSUE: `i_valid`=1 with `i_data`=0xFF throughout ISSUE -> no write occurs, and the next frame's element 0 is the first sample after `o_ready` rises.
- Reset mid-ISSUE:
  - Stimulus: pull `i_RESET` low during pair 1.
  - Required: all outputs reach their reset values immediately.
  - Required: a following frame 0xA1..0xA8 yields (0xA1,0xA5) first.
- Back-to-back frames: two frames with `i_valid`=1 and `i_ready`=1 continuously -> exactly 12 cycles per frame, with correct pairs for both frames.
